// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives an async-read instruction memory,
// buffers {pc, instr} in a small skid FIFO and hands them to decode via valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [31:0]   buf_pc    [FIFO_DEPTH];

  logic fire;
  logic push;
  logic pop;
  logic redirect_lsb_unused;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_instr = buf_instr[rd_ptr];
  assign out_pc    = buf_pc[rd_ptr];
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_comb begin
    fire = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = fetch_en & ~redirect_valid & ((count < DEPTH_C) | fire);
    pop  = fire & ~redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: any handshake in this cycle is discarded along with the queue.
      pc     <= {redirect_pc[31:2], 2'b00};
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        buf_instr[wr_ptr] <= imem_data;
        buf_pc[wr_ptr]    <= pc;
        wr_ptr            <= wr_ptr + PW'(1);
        pc                <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
